// File: rtl/ber_align_ctrl.sv
// Delay-alignment sequencer for the BER checker: sweeps every PRBS-to-slicer delay,
// scores each over a fixed compare window, locks the best one and accumulates BER counts.
module ber_align_ctrl #(
  parameter int BUFFER    = 16,
  parameter int DELAY     = $clog2(BUFFER),
  parameter int FLUSH_LEN = 16,
  parameter int WIN_LEN   = 128,
  parameter int ERR_THR   = 8,
  parameter int CNT_W     = 32,
  parameter int WIN_W     = $clog2(WIN_LEN + 1)
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_valid,
  input  logic             i_cmp_valid,
  input  logic             i_err,
  output logic [DELAY-1:0] o_delay_sel,
  output logic             o_chk_clear,
  output logic [2:0]       o_state,
  output logic             o_locked,
  output logic             o_fail,
  output logic [WIN_W-1:0] o_best_err,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int FL_W = $clog2(FLUSH_LEN + 1);

  localparam logic [DELAY-1:0] LAST_SEL   = DELAY'(BUFFER - 1);
  localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(FLUSH_LEN - 1);
  localparam logic [FL_W-1:0]  FLUSH_DONE = FL_W'(FLUSH_LEN);
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WIN_LEN - 1);
  localparam logic [31:0]      THR        = 32'(ERR_THR);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_SCAN   = 3'd2,
    S_EVAL   = 3'd3,
    S_LOCKED = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [DELAY-1:0] delay_sel_reg, delay_sel_next;
  logic [DELAY-1:0] best_sel_reg, best_sel_next;
  logic [WIN_W-1:0] best_err_reg, best_err_next;
  logic [WIN_W-1:0] best_out_reg, best_out_next;
  logic [WIN_W-1:0] win_cnt_reg, win_cnt_next;
  logic [WIN_W-1:0] err_win_reg, err_win_next;
  logic [FL_W-1:0]  flush_cnt_reg, flush_cnt_next;
  logic             chk_clear_reg, chk_clear_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;

  logic             cmp_hit;
  logic             sweep_idle;
  logic             eval_better;
  logic [WIN_W-1:0] eval_err;
  logic [DELAY-1:0] eval_sel;

  assign cmp_hit     = i_valid && i_cmp_valid;
  assign sweep_idle  = (state_reg == S_IDLE) || (state_reg == S_LOCKED) || (state_reg == S_FAIL);
  // Strict less-than: on a tie the earlier (lower) delay keeps the crown.
  assign eval_better = err_win_reg < best_err_reg;
  assign eval_err    = eval_better ? err_win_reg : best_err_reg;
  assign eval_sel    = eval_better ? delay_sel_reg : best_sel_reg;

  always_comb begin
    state_next     = state_reg;
    delay_sel_next = delay_sel_reg;
    best_sel_next  = best_sel_reg;
    best_err_next  = best_err_reg;
    best_out_next  = best_out_reg;
    win_cnt_next   = win_cnt_reg;
    err_win_next   = err_win_reg;
    flush_cnt_next = flush_cnt_reg;
    chk_clear_next = chk_clear_reg;
    bit_cnt_next   = bit_cnt_reg;
    err_cnt_next   = err_cnt_reg;

    if (i_enable) begin
      chk_clear_next = 1'b0;
      if (i_stop) begin
        state_next = S_IDLE;
      end else if (i_start && sweep_idle) begin
        state_next     = S_FLUSH;
        delay_sel_next = '0;
        best_err_next  = '1;
        best_sel_next  = '0;
        bit_cnt_next   = '0;
        err_cnt_next   = '0;
        flush_cnt_next = '0;
        chk_clear_next = 1'b1;
      end else begin
        case (state_reg)
          S_FLUSH: begin
            if (i_valid) begin
              if (flush_cnt_reg == FLUSH_LAST) begin
                state_next   = S_SCAN;
                win_cnt_next = '0;
                err_win_next = '0;
              end else begin
                flush_cnt_next = flush_cnt_reg + 1'b1;
              end
            end
          end
          S_SCAN: begin
            if (cmp_hit) begin
              win_cnt_next = win_cnt_reg + 1'b1;
              err_win_next = err_win_reg + {{(WIN_W-1){1'b0}}, i_err};
              if (win_cnt_reg == WIN_LAST) state_next = S_EVAL;
            end
          end
          S_EVAL: begin
            best_err_next = eval_err;
            best_sel_next = eval_sel;
            if (delay_sel_reg != LAST_SEL) begin
              delay_sel_next = delay_sel_reg + 1'b1;
              flush_cnt_next = '0;
              chk_clear_next = 1'b1;
              state_next     = S_FLUSH;
            end else begin
              delay_sel_next = eval_sel;
              best_out_next  = eval_err;
              if (32'(eval_err) <= THR) begin
                flush_cnt_next = '0;
                chk_clear_next = 1'b1;
                state_next     = S_LOCKED;
              end else begin
                state_next = S_FAIL;
              end
            end
          end
          S_LOCKED: begin
            // Let the checker history refill before any compare is counted.
            if (flush_cnt_reg != FLUSH_DONE) begin
              if (i_valid) flush_cnt_next = flush_cnt_reg + 1'b1;
            end else if (cmp_hit) begin
              if (bit_cnt_reg != '1) bit_cnt_next = bit_cnt_reg + 1'b1;
              if (i_err && (err_cnt_reg != '1)) err_cnt_next = err_cnt_reg + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg     <= S_IDLE;
      delay_sel_reg <= '0;
      best_sel_reg  <= '0;
      best_err_reg  <= '0;
      best_out_reg  <= '0;
      win_cnt_reg   <= '0;
      err_win_reg   <= '0;
      flush_cnt_reg <= '0;
      chk_clear_reg <= 1'b0;
      bit_cnt_reg   <= '0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      delay_sel_reg <= delay_sel_next;
      best_sel_reg  <= best_sel_next;
      best_err_reg  <= best_err_next;
      best_out_reg  <= best_out_next;
      win_cnt_reg   <= win_cnt_next;
      err_win_reg   <= err_win_next;
      flush_cnt_reg <= flush_cnt_next;
      chk_clear_reg <= chk_clear_next;
      bit_cnt_reg   <= bit_cnt_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  assign o_delay_sel = delay_sel_reg;
  assign o_chk_clear = chk_clear_reg;
  assign o_state     = state_reg;
  assign o_locked    = (state_reg == S_LOCKED);
  assign o_fail      = (state_reg == S_FAIL);
  assign o_best_err  = best_out_reg;
  assign o_bit_cnt   = bit_cnt_reg;
  assign o_err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_ber_align_ctrl.sv
// Bench for ber_align_ctrl: per-delay periodic error profiles make each window score exact,
// so the expected lock/fail decision follows from min/argmin over the profile.
module tb_ber_align_ctrl;

  logic clock, i_reset, i_enable, i_start, i_stop, i_valid, i_cmp_valid, i_err;

  logic [3:0]  delay_sel;
  logic        chk_clear, locked, fail;
  logic [2:0]  state;
  logic [7:0]  best_err;
  logic [31:0] bit_cnt, err_cnt;

  logic [1:0]  s_delay_sel;
  logic        s_chk_clear, s_locked, s_fail;
  logic [2:0]  s_state;
  logic [2:0]  s_best_err;
  logic [3:0]  s_bit_cnt, s_err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int period[16];
  int g = 0;

  ber_align_ctrl dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_start(i_start),
    .i_stop(i_stop), .i_valid(i_valid), .i_cmp_valid(i_cmp_valid), .i_err(i_err),
    .o_delay_sel(delay_sel), .o_chk_clear(chk_clear), .o_state(state),
    .o_locked(locked), .o_fail(fail), .o_best_err(best_err),
    .o_bit_cnt(bit_cnt), .o_err_cnt(err_cnt)
  );

  ber_align_ctrl #(.BUFFER(4), .FLUSH_LEN(2), .WIN_LEN(4), .ERR_THR(4), .CNT_W(4)) dut_sat (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_start(i_start),
    .i_stop(i_stop), .i_valid(i_valid), .i_cmp_valid(i_cmp_valid), .i_err(i_err),
    .o_delay_sel(s_delay_sel), .o_chk_clear(s_chk_clear), .o_state(s_state),
    .o_locked(s_locked), .o_fail(s_fail), .o_best_err(s_best_err),
    .o_bit_cnt(s_bit_cnt), .o_err_cnt(s_err_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Checker emulation: at a delay with period P, every P-th compare is an error,
  // so any 128 consecutive compares hold exactly 128/P errors.
  task automatic drive(input bit cont);
    i_valid     = cont ? 1'b1 : (($urandom % 8) != 0);
    i_cmp_valid = cont ? 1'b1 : (($urandom % 8) != 0);
    if (i_valid && i_cmp_valid) begin
      i_err = (period[delay_sel] != 0) && ((g % period[delay_sel]) == 0);
      g++;
    end else begin
      i_err = 1'($urandom % 2);
    end
  endtask

  task automatic run_sweep(input string name, input bit cont, input bit poke);
    int cnt [16];
    int exp_best, exp_sel, cycles, clears;
    bit exp_lock, timed_out, poke_pending, poked;
    exp_best = 1000; exp_sel = 0;
    for (int d = 0; d < 16; d++) begin
      cnt[d] = (period[d] == 0) ? 0 : 128 / period[d];
      if (cnt[d] < exp_best) begin exp_best = cnt[d]; exp_sel = d; end
    end
    exp_lock = (exp_best <= 8);
    cycles = 0; clears = 0; timed_out = 1'b1; poke_pending = 0; poked = 0;
    @(negedge clock);
    i_start = 1'b1;
    drive(cont);
    for (int i = 0; i < 20000; i++) begin
      @(negedge clock);
      cycles++;
      i_start = 1'b0;
      if (chk_clear) clears++;
      if (poke_pending) begin
        check({name, "_start_ignored"}, delay_sel, 7);
        poke_pending = 0;
      end
      if (locked || fail) begin timed_out = 1'b0; break; end
      if (poke && !poked && delay_sel == 4'd7 && state == 3'd2) begin
        i_start = 1'b1; poked = 1; poke_pending = 1;
      end
      drive(cont);
    end
    check({name, "_timeout"}, timed_out, 0);
    check({name, "_locked"}, locked, exp_lock);
    check({name, "_fail"}, fail, !exp_lock);
    check({name, "_sel"}, delay_sel, exp_sel);
    check({name, "_best"}, best_err, exp_best);
    check({name, "_clears"}, clears, 16 + int'(exp_lock));
    if (cont) check({name, "_cycles"}, cycles, 16 * (16 + 128 + 1) + 1);
    $display("[TB] sweep %s: best=%0d sel=%0d lock=%0d cycles=%0d", name, exp_best, exp_sel, exp_lock, cycles);
  endtask

  initial begin
    int k;
    i_reset = 1'b0; i_enable = 1'b1; i_start = 1'b0; i_stop = 1'b0;
    i_valid = 1'b0; i_cmp_valid = 1'b0; i_err = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_state", state, 0);
    check("rst_sel", delay_sel, 0);
    check("rst_locked", locked, 0);
    check("rst_fail", fail, 0);
    check("rst_best", best_err, 0);
    check("rst_bits", bit_cnt, 0);
    check("rst_errs", err_cnt, 0);
    check("rst_clear", chk_clear, 0);
    i_reset = 1'b1;

    // Only delay 5 is clean; continuous strobes also pin the sweep duration.
    for (int d = 0; d < 16; d++) period[d] = 2;
    period[5] = 0;
    run_sweep("clean5", 1'b1, 1'b0);

    // Locked accumulation: FLUSH_LEN erroneous compares are skipped, then 1000 compares.
    for (int i = 0; i < 16; i++) begin
      i_valid = 1'b1; i_cmp_valid = 1'b1; i_err = 1'b1;
      @(negedge clock);
    end
    check("lk_flush_bits", bit_cnt, 0);
    check("lk_flush_errs", err_cnt, 0);
    k = 0;
    for (int i = 0; i < 5000 && k < 1000; i++) begin
      i_valid = (($urandom % 4) != 0); i_cmp_valid = (($urandom % 4) != 0);
      if (i_valid && i_cmp_valid) begin i_err = ((k % 100) == 99); k++; end
      else i_err = 1'($urandom % 2);
      @(negedge clock);
    end
    check("lk_bits", bit_cnt, 1000);
    check("lk_errs", err_cnt, 10);
    $display("[TB] locked count: bits=%0d errs=%0d", bit_cnt, err_cnt);

    // Enable low freezes everything, even against stop and compares.
    i_enable = 1'b0; i_stop = 1'b1; i_valid = 1'b1; i_cmp_valid = 1'b1; i_err = 1'b1;
    repeat (30) @(negedge clock);
    check("frz_state", state, 4);
    check("frz_bits", bit_cnt, 1000);
    check("frz_errs", err_cnt, 10);
    i_enable = 1'b1;
    @(negedge clock);
    i_stop = 1'b0; i_valid = 1'b0;
    check("stop_state", state, 0);
    check("stop_locked", locked, 0);
    check("stop_bits", bit_cnt, 1000);
    check("stop_errs", err_cnt, 10);
    check("stop_sel", delay_sel, 5);
    $display("[TB] freeze+stop: state=%0d bits=%0d", state, bit_cnt);

    // Tie between 3 and 9, plus a start pulse mid-scan that must be ignored.
    for (int d = 0; d < 16; d++) period[d] = 4;
    period[3] = 0; period[9] = 0;
    run_sweep("tie3_9", 1'b0, 1'b1);

    // Every delay scores at least 16 errors -> FAIL at the lowest-error delay.
    for (int d = 0; d < 16; d++) period[d] = 1 << ($urandom % 4);
    run_sweep("all_bad", 1'b0, 1'b0);

    // Simultaneous start and stop from FAIL resolves to IDLE.
    @(negedge clock);
    i_start = 1'b1; i_stop = 1'b1;
    @(negedge clock);
    i_start = 1'b0; i_stop = 1'b0;
    check("startstop_state", state, 0);
    check("startstop_fail", fail, 0);
    $display("[TB] start+stop: state=%0d", state);

    // Best window exactly at threshold (8 errors) still locks.
    for (int d = 0; d < 16; d++) period[d] = 1 << ($urandom % 4);
    period[$urandom % 16] = 16;
    run_sweep("thr_edge", 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < 16; d++)
        period[d] = (($urandom % 10) == 0) ? 0 : (1 << ($urandom % 8));
      run_sweep($sformatf("rand%0d", r), 1'b0, 1'b0);
    end

    // Asynchronous reset while scanning delay 2.
    for (int d = 0; d < 16; d++) period[d] = 2;
    @(negedge clock);
    i_start = 1'b1;
    drive(1'b1);
    k = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      i_start = 1'b0;
      if (delay_sel == 4'd2 && state == 3'd2) begin k = 1; break; end
      drive(1'b1);
    end
    check("rst_mid_reach", k, 1);
    repeat (5) begin drive(1'b1); @(negedge clock); end
    i_reset = 1'b0;
    #1;
    check("arst_state_now", state, 0);
    @(negedge clock);
    check("arst_state", state, 0);
    check("arst_sel", delay_sel, 0);
    check("arst_best", best_err, 0);
    check("arst_bits", bit_cnt, 0);
    check("arst_clear", chk_clear, 0);
    check("arst_locked", locked, 0);
    i_reset = 1'b1;
    @(negedge clock);
    check("arst_stay_idle", state, 0);
    $display("[TB] reset mid-scan: state=%0d sel=%0d", state, delay_sel);

    // Narrow-counter instance: continuous errors, counters stick at 15.
    i_start = 1'b1; i_valid = 1'b1; i_cmp_valid = 1'b1; i_err = 1'b1;
    k = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      k++;
      i_start = 1'b0;
      if (s_locked || s_fail) break;
    end
    check("sat_cycles", k, 4 * (2 + 4 + 1) + 1);
    check("sat_locked", s_locked, 1);
    check("sat_sel", s_delay_sel, 0);
    check("sat_best", s_best_err, 4);
    repeat (2) @(negedge clock);
    check("sat_flush_bits", s_bit_cnt, 0);
    repeat (10) @(negedge clock);
    check("sat_bits10", s_bit_cnt, 10);
    check("sat_errs10", s_err_cnt, 10);
    repeat (20) @(negedge clock);
    check("sat_bits", s_bit_cnt, 15);
    check("sat_errs", s_err_cnt, 15);
    i_enable = 1'b0; i_stop = 1'b1;
    repeat (3) @(negedge clock);
    check("sat_frz_state", s_state, 4);
    i_enable = 1'b1;
    @(negedge clock);
    i_stop = 1'b0; i_valid = 1'b0;
    check("sat_stop_state", s_state, 0);
    check("sat_stop_bits", s_bit_cnt, 15);
    check("sat_stop_errs", s_err_cnt, 15);
    check("main_stop_state", state, 0);
    $display("[TB] saturation: bits=%0d errs=%0d state=%0d", s_bit_cnt, s_err_cnt, s_state);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
